// File: rtl/alu_functional_unit.sv
// Three-stage pipelined integer ALU with a one-entry skid buffer, feeding one CDB port.
// Optional FU_FLUSH_EN adds a flush input that empties the pipe while keeping overflow_err.
module alu_functional_unit #(
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 4,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef FU_FLUSH_EN
  input  logic               flush,
`endif
  input  logic               in_valid,
  input  logic [IDX_W-1:0]   in_rob_index,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [DATA_W-1:0]  in_val1,
  input  logic [DATA_W-1:0]  in_val2,
  output logic               busy,
  output logic               cdb_req,
  output logic [IDX_W-1:0]   cdb_rob_index,
  output logic [DATA_W-1:0]  cdb_result,
  input  logic               cdb_grant,
  output logic               overflow_err
);

`ifndef FU_FLUSH_EN
  logic flush;
  assign flush = 1'b0;
`endif

  logic              s1_v, s2_v, s3_v, skid_v;
  logic [IDX_W-1:0]  s1_idx, s2_idx, s3_idx, skid_idx;
  logic [3:0]        s1_op, skid_op;
  logic [DATA_W-1:0] s1_a, s1_b, skid_a, skid_b;
  logic [DATA_W-1:0] s2_res, s3_res;

  logic s3_free, s2_free, s1_free, stall3;
  logic s1_next, s2_next, s3_next, skid_next, busy_next, drop;
  logic [DATA_W-1:0] alu_res;

  // A stage frees up when it is empty or its occupant moves on this cycle.
  always_comb begin
    stall3    = s3_v & ~cdb_grant;
    s3_free   = ~stall3;
    s2_free   = ~(s2_v & stall3);
    s1_free   = ~(s1_v & s2_v & stall3);
    s3_next   = s3_free ? s2_v : 1'b1;
    s2_next   = s2_free ? s1_v : 1'b1;
    s1_next   = s1_free ? (skid_v | in_valid) : 1'b1;
    skid_next = s1_free ? (skid_v & in_valid) : (skid_v | in_valid);
    drop      = in_valid & skid_v & ~s1_free;
    busy_next = skid_next | (s1_next & s2_next & s3_next & stall3);
  end

  always_comb begin
    alu_res = s1_a;
    case (s1_op)
      4'd0:    alu_res = s1_a + s1_b;
      4'd1:    alu_res = s1_a - s1_b;
      4'd2:    alu_res = s1_a & s1_b;
      4'd3:    alu_res = s1_a | s1_b;
      4'd4:    alu_res = s1_a ^ s1_b;
      4'd5:    alu_res = s1_a << s1_b[3:0];
      4'd6:    alu_res = s1_a >> s1_b[3:0];
      4'd7:    alu_res = {{(DATA_W-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
      default: alu_res = s1_a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v          <= 1'b0;
      s2_v          <= 1'b0;
      s3_v          <= 1'b0;
      skid_v        <= 1'b0;
      busy          <= 1'b0;
      s3_idx        <= '0;
      s3_res        <= '0;
      overflow_err  <= 1'b0;
    end else if (flush) begin
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      s3_v   <= 1'b0;
      skid_v <= 1'b0;
      busy   <= 1'b0;
    end else begin
      s1_v   <= s1_next;
      s2_v   <= s2_next;
      s3_v   <= s3_next;
      skid_v <= skid_next;
      busy   <= busy_next;
      if (drop)
        overflow_err <= 1'b1;
      if (s3_free && s2_v) begin
        s3_idx <= s2_idx;
        s3_res <= s2_res;
      end
      if (s2_free && s1_v) begin
        s2_idx <= s1_idx;
        s2_res <= alu_res;
      end
      // The skid entry is older than the current issue, so it always wins S1.
      if (s1_free) begin
        if (skid_v) begin
          s1_idx <= skid_idx;
          s1_op  <= skid_op;
          s1_a   <= skid_a;
          s1_b   <= skid_b;
        end else if (in_valid) begin
          s1_idx <= in_rob_index;
          s1_op  <= in_instr[INSTR_W-1 -: 4];
          s1_a   <= in_val1;
          s1_b   <= in_val2;
        end
      end
      if (in_valid && (s1_free ? skid_v : !skid_v)) begin
        skid_idx <= in_rob_index;
        skid_op  <= in_instr[INSTR_W-1 -: 4];
        skid_a   <= in_val1;
        skid_b   <= in_val2;
      end
    end
  end

  assign cdb_req       = s3_v;
  assign cdb_rob_index = s3_idx;
  assign cdb_result    = s3_res;

endmodule

// File: tb/tb_alu_functional_unit.sv
// Directed self-checking bench for alu_functional_unit: inputs driven and outputs sampled on negedge.
module tb_alu_functional_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
`ifdef FU_FLUSH_EN
  logic        flush = 1'b0;
`endif
  logic        in_valid = 1'b0;
  logic [3:0]  in_rob_index = '0;
  logic [15:0] in_instr = '0;
  logic [15:0] in_val1 = '0;
  logic [15:0] in_val2 = '0;
  logic        busy;
  logic        cdb_req;
  logic [3:0]  cdb_rob_index;
  logic [15:0] cdb_result;
  logic        cdb_grant = 1'b1;
  logic        overflow_err;

  int checks = 0;
  int failures = 0;

  logic [3:0]  v_idx [8];
  logic [3:0]  v_op  [8];
  logic [15:0] v_a   [8];
  logic [15:0] v_b   [8];
  logic [15:0] v_exp [8];

  alu_functional_unit dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef FU_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid),
    .in_rob_index(in_rob_index),
    .in_instr(in_instr),
    .in_val1(in_val1),
    .in_val2(in_val2),
    .busy(busy),
    .cdb_req(cdb_req),
    .cdb_rob_index(cdb_rob_index),
    .cdb_result(cdb_result),
    .cdb_grant(cdb_grant),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic setVec(input int i, input logic [3:0] idx, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
    v_idx[i] = idx;
    v_op[i]  = op;
    v_a[i]   = a;
    v_b[i]   = b;
    v_exp[i] = e;
  endtask

  task automatic driveVec(input int i);
    in_valid     = 1'b1;
    in_rob_index = v_idx[i];
    in_instr     = {v_op[i], 12'h000};
    in_val1      = v_a[i];
    in_val2      = v_b[i];
  endtask

  // Issue n vectors back to back with grant held high; results must follow three cycles later.
  task automatic applyStimulus(input int n);
    cdb_grant = 1'b1;
    for (int c = 0; c < n + 3; c++) begin
      if (c < n) driveVec(c);
      else in_valid = 1'b0;
      checkOutput("busy_stream", busy, 0);
      if (c >= 3) begin
        checkOutput("req_stream", cdb_req, 1);
        checkOutput("idx_stream", cdb_rob_index, v_idx[c-3]);
        checkOutput("res_stream", cdb_result, v_exp[c-3]);
      end else begin
        checkOutput("latency_req", cdb_req, 0);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("drain_req", cdb_req, 0);
  endtask

  // Issue n vectors with grant low, hold, then release grant and expect the first four in order.
  task automatic runStall(input int n, input logic exp_ovf);
    cdb_grant = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c < n) driveVec(c);
      else in_valid = 1'b0;
      if (c >= 3) begin
        checkOutput("stall_req", cdb_req, 1);
        checkOutput("stall_idx", cdb_rob_index, v_idx[0]);
        checkOutput("stall_res", cdb_result, v_exp[0]);
        checkOutput("stall_busy", busy, (c >= 4) ? 1 : 0);
      end
      if (c == 5) checkOutput("ovf_set", overflow_err, exp_ovf);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    cdb_grant = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checkOutput("drain_req", cdb_req, 1);
      checkOutput("drain_idx", cdb_rob_index, v_idx[k]);
      checkOutput("drain_res", cdb_result, v_exp[k]);
      if (k >= 1) checkOutput("drain_busy", busy, 0);
      @(negedge clk);
    end
    checkOutput("drain_empty", cdb_req, 0);
    checkOutput("drain_ovf", overflow_err, exp_ovf);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_req", cdb_req, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_idx", cdb_rob_index, 0);
    checkOutput("rst_res", cdb_result, 0);
    checkOutput("rst_ovf", overflow_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD wrapping into the sign bit
    setVec(0, 4'd3, 4'd0, 16'h7FFF, 16'h0001, 16'h8000);
    applyStimulus(1);

    // Operation coverage
    setVec(0, 4'd1, 4'd1, 16'h0000, 16'h0001, 16'hFFFF);
    setVec(1, 4'd2, 4'd5, 16'h0001, 16'h0013, 16'h0008);
    setVec(2, 4'd3, 4'd7, 16'hFFFF, 16'h0001, 16'h0001);
    setVec(3, 4'd4, 4'd9, 16'h1234, 16'h5555, 16'h1234);
    setVec(4, 4'd5, 4'd6, 16'h8000, 16'h0004, 16'h0800);
    setVec(5, 4'd6, 4'd7, 16'h0001, 16'hFFFF, 16'h0000);
    setVec(6, 4'd7, 4'd4, 16'hAAAA, 16'h0FF0, 16'hA55A);
    setVec(7, 4'd8, 4'd3, 16'h1200, 16'h0034, 16'h1234);
    applyStimulus(8);

    // Back-to-back AND
    for (int i = 0; i < 4; i++)
      setVec(i, 4'(i + 1), 4'd2, 16'hF0F0, 16'h0FF0, 16'h00F0);
    applyStimulus(4);

    // Stall with pipe and skid full, no overflow
    for (int i = 0; i < 4; i++)
      setVec(i, 4'(i + 5), 4'd3, 16'(i + 5), 16'h0100, 16'(16'h0105 + i));
    runStall(4, 1'b0);

    // Fifth issue overflows and is dropped
    for (int i = 0; i < 5; i++)
      setVec(i, 4'(i + 9), 4'd4, 16'hFF00, 16'(i + 9), 16'(16'hFF09 + i));
    runStall(5, 1'b1);

`ifdef FU_FLUSH_EN
    cdb_grant = 1'b0;
    for (int c = 0; c < 3; c++) begin
      driveVec(c);
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_req", cdb_req, 0);
    checkOutput("flush_busy", busy, 0);
    checkOutput("flush_ovf", overflow_err, 1);
    cdb_grant = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("flush_stale", cdb_req, 0);
    end
`endif

    // Reset with three instructions in flight
    cdb_grant = 1'b0;
    for (int c = 0; c < 3; c++) begin
      driveVec(c);
      @(negedge clk);
    end
    checkOutput("pre_rst_req", cdb_req, 1);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_req", cdb_req, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_idx", cdb_rob_index, 0);
    checkOutput("mid_rst_res", cdb_result, 0);
    checkOutput("mid_rst_ovf", overflow_err, 0);
    rst_n     = 1'b1;
    cdb_grant = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("post_rst_stale", cdb_req, 0);
      checkOutput("post_rst_busy", busy, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
